// File: rtl/pc_unit_if.sv
// Fetch-PC control/status bundle between branch/control logic and pc_unit.
// Exception signals exist only when PC_EXC_EN is defined.
interface pc_unit_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic             call;
  logic [WIDTH-1:0] jump_target;
  logic             ret;
  logic [WIDTH-1:0] ret_fallback;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_inc;
  logic             redirect;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
`ifdef PC_EXC_EN
  logic             exc_req;
  logic [WIDTH-1:0] exc_vector;
  logic [WIDTH-1:0] epc;
`endif

  modport master (
    output stall, branch_taken, branch_target, jump, call, jump_target,
           ret, ret_fallback,
`ifdef PC_EXC_EN
    output exc_req, exc_vector,
    input  epc,
`endif
    input  pc, pc_plus_inc, redirect, ras_count, ras_empty
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, call, jump_target,
           ret, ret_fallback,
`ifdef PC_EXC_EN
    input  exc_req, exc_vector,
    output epc,
`endif
    output pc, pc_plus_inc, redirect, ras_count, ras_empty
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter with branch/jump/call/return selection and a
// circular return-address stack. Define PC_EXC_EN to add exception redirect.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      ALIGN_BITS   = 2,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  function automatic logic [WIDTH-1:0] align_tgt(input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] m;
    m = '1;
    m = m << ALIGN_BITS;
    return a & m;
  endfunction

  logic [WIDTH-1:0] pc_p0;
  logic             redirect_p0;
  logic [PTR_W-1:0] tp_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
`ifdef PC_EXC_EN
  logic [WIDTH-1:0] epc_p0;
`endif

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_nxt;
  logic             redir_nxt;
  logic             do_push;
  logic             do_pop;
  logic             do_exc;
  logic [PTR_W-1:0] tp_m1;

  assign pc_inc = pc_p0 + WIDTH'(INC);
  assign tp_m1  = tp_p0 - PTR_W'(1);

  // Next-PC select: exception > stall > branch > ret > jump/call > sequential
  always_comb begin
    pc_nxt    = pc_inc;
    redir_nxt = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_exc    = 1'b0;
`ifdef PC_EXC_EN
    if (bus.exc_req) begin
      pc_nxt    = align_tgt(bus.exc_vector);
      redir_nxt = 1'b1;
      do_exc    = 1'b1;
    end else
`endif
    if (bus.stall) begin
      pc_nxt    = pc_p0;
      redir_nxt = redirect_p0;
    end else if (bus.branch_taken) begin
      pc_nxt    = align_tgt(bus.branch_target);
      redir_nxt = 1'b1;
    end else if (bus.ret) begin
      redir_nxt = 1'b1;
      if (cnt_p0 != '0) begin
        pc_nxt = align_tgt(ras_mem[tp_m1]);
        do_pop = 1'b1;
      end else begin
        pc_nxt = align_tgt(bus.ret_fallback);
      end
    end else if (bus.jump) begin
      pc_nxt    = align_tgt(bus.jump_target);
      redir_nxt = 1'b1;
      do_push   = bus.call;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0       <= RESET_VECTOR;
      redirect_p0 <= 1'b0;
      tp_p0       <= '0;
      cnt_p0      <= '0;
    end else begin
      pc_p0       <= pc_nxt;
      redirect_p0 <= redir_nxt;
      if (do_push) begin
        tp_p0 <= tp_p0 + PTR_W'(1);
        if (cnt_p0 != CNT_W'(RAS_DEPTH))
          cnt_p0 <= cnt_p0 + CNT_W'(1);
      end else if (do_pop) begin
        tp_p0  <= tp_m1;
        cnt_p0 <= cnt_p0 - CNT_W'(1);
      end
    end
  end

  // Stack contents are plain storage; overflow overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (!rst && do_push)
      ras_mem[tp_p0] <= pc_inc;
  end

`ifdef PC_EXC_EN
  always_ff @(posedge clk) begin
    if (rst)
      epc_p0 <= '0;
    else if (do_exc)
      epc_p0 <= pc_p0;
  end
  assign bus.epc = epc_p0;
`else
  logic unused_exc;
  assign unused_exc = do_exc;
`endif

  assign bus.pc          = pc_p0;
  assign bus.pc_plus_inc = pc_inc;
  assign bus.redirect    = redirect_p0;
  assign bus.ras_count   = cnt_p0;
  assign bus.ras_empty   = (cnt_p0 == '0);
endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit with hand-computed expectations.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

  pc_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h0040_0000), .INC(4),
    .ALIGN_BITS(2), .RAS_DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.branch_taken = 0; bus.jump = 0; bus.call = 0; bus.ret = 0;
`ifdef PC_EXC_EN
    bus.exc_req = 0;
`endif
  endtask

  task automatic jump_to(input logic [31:0] t);
    idle();
    bus.jump = 1; bus.jump_target = t;
    step();
    idle();
  endtask

  logic [31:0] calls [5] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
  logic [31:0] rets  [5] = '{32'h54, 32'h44, 32'h34, 32'h24, 32'hABC};
  logic [2:0]  cnt_c [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
  logic [2:0]  cnt_r [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};

  initial begin
    rst = 1;
    idle();
    bus.branch_target = '0; bus.jump_target = '0; bus.ret_fallback = '0;
`ifdef PC_EXC_EN
    bus.exc_vector = '0;
`endif
    step();
    chk("rst_pc", bus.pc, 32'h0040_0000);
    chk("rst_redirect", bus.redirect, 0);
    chk("rst_count", bus.ras_count, 0);
    chk("rst_empty", bus.ras_empty, 1);
    chk("rst_pc_plus_inc", bus.pc_plus_inc, 32'h0040_0004);
`ifdef PC_EXC_EN
    chk("rst_epc", bus.epc, 0);
`endif
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq_pc", bus.pc, 32'h0040_0000 + 4 * i);
      chk("seq_redirect", bus.redirect, 0);
    end

    // branch beats jump, target aligned
    jump_to(32'h100);
    chk("jmp_pc", bus.pc, 32'h100);
    chk("jmp_redirect", bus.redirect, 1);
    bus.branch_taken = 1; bus.branch_target = 32'h203;
    bus.jump = 1; bus.jump_target = 32'h300;
    step();
    idle();
    chk("br_pc", bus.pc, 32'h200);
    chk("br_redirect", bus.redirect, 1);
    step();
    chk("br_next_pc", bus.pc, 32'h204);
    chk("br_next_redirect", bus.redirect, 0);

    // stall freezes pc while a jump is held
    jump_to(32'h100);
    bus.stall = 1; bus.jump = 1; bus.jump_target = 32'h500;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.pc, 32'h100);
    end
    bus.stall = 0;
    step();
    idle();
    chk("unstall_pc", bus.pc, 32'h500);
    chk("unstall_redirect", bus.redirect, 1);

    // RAS overflow then drain past empty
    for (int i = 0; i < 5; i++) begin
      jump_to(calls[i]);
      bus.jump = 1; bus.call = 1; bus.jump_target = 32'h1000;
      step();
      idle();
      chk("call_pc", bus.pc, 32'h1000);
      chk("call_count", bus.ras_count, cnt_c[i]);
    end
    bus.ret_fallback = 32'hABC;
    bus.ret = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ret_pc", bus.pc, rets[i]);
      chk("ret_count", bus.ras_count, cnt_r[i]);
    end
    idle();
    chk("ret_empty", bus.ras_empty, 1);

    // dropped ret does not pop; ret beats call
    bus.jump = 1; bus.call = 1; bus.jump_target = 32'h1000;
    step();
    idle();
    chk("push1_count", bus.ras_count, 1);
    bus.branch_taken = 1; bus.branch_target = 32'h600; bus.ret = 1;
    step();
    idle();
    chk("drop_ret_pc", bus.pc, 32'h600);
    chk("drop_ret_count", bus.ras_count, 1);
    bus.ret = 1; bus.jump = 1; bus.call = 1; bus.jump_target = 32'h2000;
    step();
    idle();
    chk("ret_call_pc", bus.pc, 32'hAC0);
    chk("ret_call_count", bus.ras_count, 0);

    // wrap and reset during stall
    jump_to(32'hFFFF_FFFC);
    step();
    chk("wrap_pc", bus.pc, 32'h0);
    bus.jump = 1; bus.call = 1; bus.jump_target = 32'h700;
    step();
    idle();
    chk("wrap_call_count", bus.ras_count, 1);
    bus.stall = 1;
    step();
    rst = 1;
    step();
    rst = 0;
    idle();
    chk("rst_stall_pc", bus.pc, 32'h0040_0000);
    chk("rst_stall_count", bus.ras_count, 0);
    chk("rst_stall_redirect", bus.redirect, 0);

`ifdef PC_EXC_EN
    jump_to(32'h300);
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h900;
    bus.exc_req = 1; bus.exc_vector = 32'h8000_0180;
    step();
    bus.exc_req = 0; bus.branch_taken = 0;
    chk("exc_pc", bus.pc, 32'h8000_0180);
    chk("exc_epc", bus.epc, 32'h300);
    chk("exc_redirect", bus.redirect, 1);
    step();
    idle();
    chk("exc_hold_pc", bus.pc, 32'h8000_0180);
    chk("exc_hold_epc", bus.epc, 32'h300);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
